// File: rtl/cu_sequencer_if.sv
// Decoder <-> sequencer bundle: step commands in, step encodings out.
interface cu_sequencer_if #(
  parameter int STATES = 40,
  parameter int OPW    = 5,
  parameter int CNTW   = 16
);
  logic              COUNTER_LD;
  logic              COUNTER_INC;
  logic              COUNTER_CLR;
  logic [OPW-1:0]    OPCODE;
  logic              STALL;
  logic [STATES-1:0] CPU_state;
  logic [5:0]        STATE_IDX;
  logic              FETCHING;
  logic              ILLEGAL_OP;
  logic              SEQ_ERR;
  logic [CNTW-1:0]   INSTR_CNT;

  modport master (
    output COUNTER_LD, COUNTER_INC, COUNTER_CLR,
    output OPCODE, STALL,
    input  CPU_state, STATE_IDX, FETCHING,
    input  ILLEGAL_OP, SEQ_ERR, INSTR_CNT
  );

  modport slave (
    input  COUNTER_LD, COUNTER_INC, COUNTER_CLR,
    input  OPCODE, STALL,
    output CPU_state, STATE_IDX, FETCHING,
    output ILLEGAL_OP, SEQ_ERR, INSTR_CNT
  );
endinterface

// File: rtl/cu_sequencer.sv
// Control-step sequencer: 6-bit micro-step counter, one-hot step vector,
// opcode dispatch, illegal-op / protocol error flags, retired count.
module cu_sequencer #(
  parameter int STATES = 40,
  parameter int OPW    = 5,
  parameter int CNTW   = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  cu_sequencer_if.slave bus
);
  localparam int SW = 6;
  localparam logic [SW-1:0] LAST = SW'(STATES - 1);
  localparam logic [SW-1:0] NOP1 = SW'(3);
  localparam logic [SW-1:0] FET3 = SW'(2);

  logic [SW-1:0]     idx, idx_nxt;
  logic [STATES-1:0] onehot;
  logic              fetch;
  logic              ill, ill_nxt;
  logic              err, err_nxt;
  logic [CNTW-1:0]   cnt;
  logic              multi, ret, bad_op;

  function automatic logic [SW-1:0] start_step(
    input logic [OPW-1:0] op
  );
    logic [SW-1:0] s;
    case (int'(op))
      0:       s = 6'd3;
      1:       s = 6'd4;
      2:       s = 6'd5;
      3:       s = 6'd7;
      4:       s = 6'd9;
      5:       s = 6'd13;
      6:       s = 6'd17;
      7:       s = 6'd21;
      8:       s = 6'd22;
      9:       s = 6'd23;
      10:      s = 6'd24;
      11:      s = 6'd25;
      12:      s = 6'd26;
      13:      s = 6'd28;
      14:      s = 6'd30;
      15:      s = 6'd32;
      16:      s = 6'd34;
      17:      s = 6'd36;
      18:      s = 6'd38;
      default: s = NOP1;
    endcase
    return s;
  endfunction

  assign bad_op = int'(bus.OPCODE) > 18;
  assign multi  = (bus.COUNTER_CLR & bus.COUNTER_LD)
                | (bus.COUNTER_CLR & bus.COUNTER_INC)
                | (bus.COUNTER_LD  & bus.COUNTER_INC);

  always_comb begin
    idx_nxt = idx;
    err_nxt = err | multi;
    ill_nxt = 1'b0;
    if (bus.COUNTER_CLR) begin
      idx_nxt = '0;
    end else if (bus.COUNTER_LD) begin
      idx_nxt = start_step(bus.OPCODE);
      ill_nxt = bad_op;
      if (idx != FET3) err_nxt = 1'b1;
    end else if (bus.COUNTER_INC) begin
      if (idx == LAST) begin
        idx_nxt = '0;
        err_nxt = 1'b1;
      end else begin
        idx_nxt = idx + SW'(1);
      end
    end else if (idx == NOP1) begin
      // nop1 has no decoder command; return to fetch on our own
      idx_nxt = '0;
    end
  end

  assign ret = (idx >= NOP1) && (idx_nxt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      onehot <= {{(STATES-1){1'b0}}, 1'b1};
      fetch  <= 1'b1;
      ill    <= 1'b0;
      err    <= 1'b0;
      cnt    <= '0;
    end else if (!bus.STALL) begin
      idx    <= idx_nxt;
      onehot <= {{(STATES-1){1'b0}}, 1'b1} << idx_nxt;
      fetch  <= idx_nxt < NOP1;
      ill    <= ill_nxt;
      err    <= err_nxt;
      if (ret) cnt <= cnt + CNTW'(1);
    end
  end

  assign bus.STATE_IDX  = idx;
  assign bus.CPU_state  = onehot;
  assign bus.FETCHING   = fetch;
  assign bus.ILLEGAL_OP = ill;
  assign bus.SEQ_ERR    = err;
  assign bus.INSTR_CNT  = cnt;
endmodule

// File: tb/tb_cu_sequencer.sv
// Vector table + expectation queue bench for cu_sequencer.
module tb_cu_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cu_sequencer_if #(.STATES(40), .OPW(5), .CNTW(16)) bus ();

  cu_sequencer #(.STATES(40), .OPW(5), .CNTW(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit         rst;
    bit         clr;
    bit         ld;
    bit         inc;
    bit         stall;
    logic [4:0] op;
    int         idx;
    bit         ill;
    bit         err;
    int         cnt;
  } vec_t;

  typedef struct {
    int idx;
    bit ill;
    bit err;
    int cnt;
    int n;
  } exp_t;

  exp_t sb[$];
  vec_t tv[$];

  task automatic chk(input string name, input longint act,
                     input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic chk_state(input string tag, input int idx,
                           input bit ill, input bit err, input int cnt);
    logic [39:0] oh;
    oh = 40'h1 << idx;
    chk({tag, " idx"}, bus.STATE_IDX, idx);
    chk({tag, " onehot"}, bus.CPU_state, oh);
    chk({tag, " fetching"}, bus.FETCHING, idx < 3);
    chk({tag, " illegal"}, bus.ILLEGAL_OP, ill);
    chk({tag, " seq_err"}, bus.SEQ_ERR, err);
    chk({tag, " cnt"}, bus.INSTR_CNT, cnt);
  endtask

  task automatic idle();
    bus.COUNTER_CLR = 1'b0;
    bus.COUNTER_LD  = 1'b0;
    bus.COUNTER_INC = 1'b0;
    bus.STALL       = 1'b0;
    bus.OPCODE      = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_state("reset", 0, 0, 0, 0);
    rst_n = 1'b1;
  endtask

  task automatic apply(input vec_t v, input int n);
    exp_t e;
    exp_t got;
    if (v.rst) do_reset();
    @(negedge clk);
    bus.COUNTER_CLR = v.clr;
    bus.COUNTER_LD  = v.ld;
    bus.COUNTER_INC = v.inc;
    bus.STALL       = v.stall;
    bus.OPCODE      = v.op;
    e.idx = v.idx; e.ill = v.ill; e.err = v.err;
    e.cnt = v.cnt; e.n = n;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard empty actual=0 required=1");
    end else begin
      got = sb.pop_front();
      chk_state($sformatf("vec%0d", got.n), got.idx, got.ill,
                got.err, got.cnt);
    end
  endtask

  function automatic vec_t mk(input bit r, input bit c, input bit l,
                              input bit i, input bit s, input int op,
                              input int idx, input bit ill,
                              input bit err, input int cnt);
    vec_t v;
    v.rst = r; v.clr = c; v.ld = l; v.inc = i; v.stall = s;
    v.op = 5'(op); v.idx = idx; v.ill = ill; v.err = err; v.cnt = cnt;
    return v;
  endfunction

  initial begin
    idle();
    // add: 0,1,2,26,27,0
    tv.push_back(mk(1,0,0,1,0, 0,  1,0,0,0));
    tv.push_back(mk(0,0,0,1,0, 0,  2,0,0,0));
    tv.push_back(mk(0,0,1,0,0,12, 26,0,0,0));
    tv.push_back(mk(0,0,0,1,0, 0, 27,0,0,0));
    tv.push_back(mk(0,1,0,0,0, 0,  0,0,0,1));
    // illegal opcode -> nop1 with pulse, auto-return
    tv.push_back(mk(0,0,0,1,0, 0,  1,0,0,1));
    tv.push_back(mk(0,0,0,1,0, 0,  2,0,0,1));
    tv.push_back(mk(0,0,1,0,0,25,  3,1,0,1));
    tv.push_back(mk(0,0,0,0,0, 0,  0,0,0,2));
    // legal nop
    tv.push_back(mk(0,0,0,1,0, 0,  1,0,0,2));
    tv.push_back(mk(0,0,0,1,0, 0,  2,0,0,2));
    tv.push_back(mk(0,0,1,0,0, 0,  3,0,0,2));
    tv.push_back(mk(0,0,0,0,0, 0,  0,0,0,3));
    // stall in step 10
    tv.push_back(mk(0,0,0,1,0, 0,  1,0,0,3));
    tv.push_back(mk(0,0,0,1,0, 0,  2,0,0,3));
    tv.push_back(mk(0,0,1,0,0, 4,  9,0,0,3));
    tv.push_back(mk(0,0,0,1,0, 0, 10,0,0,3));
    tv.push_back(mk(0,0,0,1,1, 0, 10,0,0,3));
    tv.push_back(mk(0,0,0,1,1, 0, 10,0,0,3));
    tv.push_back(mk(0,0,0,1,1, 0, 10,0,0,3));
    tv.push_back(mk(0,0,0,1,0, 0, 11,0,0,3));
    tv.push_back(mk(0,1,0,0,0, 0,  0,0,0,4));
    // CLR+INC in step 7, sticky error
    tv.push_back(mk(0,0,0,1,0, 0,  1,0,0,4));
    tv.push_back(mk(0,0,0,1,0, 0,  2,0,0,4));
    tv.push_back(mk(0,0,1,0,0, 3,  7,0,0,4));
    tv.push_back(mk(0,1,0,1,0, 0,  0,0,1,5));
    tv.push_back(mk(0,0,0,1,0, 0,  1,0,1,5));
    // INC at 39 wraps
    tv.push_back(mk(1,0,0,1,0, 0,  1,0,0,0));
    tv.push_back(mk(0,0,0,1,0, 0,  2,0,0,0));
    tv.push_back(mk(0,0,1,0,0,18, 38,0,0,0));
    tv.push_back(mk(0,0,0,1,0, 0, 39,0,0,0));
    tv.push_back(mk(0,0,0,1,0, 0,  0,0,1,1));
    // LD outside fetch3
    tv.push_back(mk(1,0,0,1,0, 0,  1,0,0,0));
    tv.push_back(mk(0,0,0,1,0, 0,  2,0,0,0));
    tv.push_back(mk(0,0,1,0,0, 2,  5,0,0,0));
    tv.push_back(mk(0,0,1,0,0, 1,  4,0,1,0));
    tv.push_back(mk(0,1,0,0,0, 0,  0,0,1,1));
    // stalled illegal load makes no pulse
    tv.push_back(mk(0,0,0,1,0, 0,  1,0,1,1));
    tv.push_back(mk(0,0,0,1,0, 0,  2,0,1,1));
    tv.push_back(mk(0,0,1,0,1,25,  2,0,1,1));
    tv.push_back(mk(0,0,1,0,0,25,  3,1,1,1));
    tv.push_back(mk(0,0,0,0,0, 0,  0,0,1,2));
    // CLR+LD: CLR wins
    tv.push_back(mk(0,1,1,0,0, 5,  0,0,1,2));

    foreach (tv[i]) apply(tv[i], i);

    // asynchronous reset mid-routine in step 15
    do_reset();
    apply(mk(0,0,0,1,0, 0,  1,0,0,0), 100);
    apply(mk(0,0,0,1,0, 0,  2,0,0,0), 101);
    apply(mk(0,0,1,0,0, 5, 13,0,0,0), 102);
    apply(mk(0,0,0,1,0, 0, 14,0,0,0), 103);
    apply(mk(0,0,0,1,0, 0, 15,0,0,0), 104);
    @(negedge clk);
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk_state("async", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(mk(0,0,0,1,0, 0,  1,0,0,0), 105);

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard leftover actual=%0d required=0",
               sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=done");
    $fatal(1);
  end
endmodule
